// File: rtl/gfx_cmd_sched.sv
// Graphics command scheduler: in-order FIFO that releases sprite/font writes in blanking.
// Optional GFX_SCHED_COALESCE_EN merges repeated sprite-position pushes into the newest entry.
module gfx_cmd_sched #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_type,
    input  logic [4:0]    cmd_sel,
    input  logic [10:0]   cmd_a,
    input  logic [8:0]    cmd_b,
    input  logic          cmd_vis,
    input  logic          vblank,
    input  logic          hblank,
    output logic          stall,
    output logic          spr_pos_we,
    output logic          spr_attr_we,
    output logic [4:0]    spr_sel,
    output logic [9:0]    spr_x,
    output logic [8:0]    spr_y,
    output logic          spr_vis,
    output logic          font_we,
    output logic [10:0]   font_addr,
    output logic [3:0]    font_data,
    output logic [CW-1:0] fifo_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_e;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  sel;
        logic [10:0] a;
        logic [8:0]  b;
        logic        vis;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;

    logic          pos_we_q, pos_we_d;
    logic          attr_we_q, attr_we_d;
    logic          font_we_q, font_we_d;
    logic [4:0]    sel_q, sel_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic          vis_q, vis_d;
    logic [10:0]   faddr_q, faddr_d;
    logic [3:0]    fdata_q, fdata_d;

    entry_t head;
    entry_t cmd_ent;
    logic   push_ok;
    logic   merge;
    logic   alloc;
    logic   win_open;
    logic   pop;

    assign head    = mem_q[rd_ptr_q];
    assign cmd_ent = '{typ: cmd_type, sel: cmd_sel, a: cmd_a,
                       b: cmd_b, vis: cmd_vis};
    assign stall   = (count_q == CW'(DEPTH));
    assign push_ok = cmd_valid & ~stall;

`ifdef GFX_SCHED_COALESCE_EN
    logic [AW-1:0] last_ptr;
    entry_t        newest;

    assign last_ptr = wr_ptr_q - AW'(1);
    assign newest   = mem_q[last_ptr];
    // count >= 2 keeps the head (possibly popping now) out of reach
    assign merge = push_ok & (cmd_type == 2'b00) &
                   (count_q >= CW'(2)) &
                   (newest.typ == 2'b00) &
                   (newest.sel == cmd_sel);
`else
    assign merge = 1'b0;
`endif

    assign alloc = push_ok & ~merge;

    always_comb begin
        win_open = 1'b1;
        unique case (head.typ)
            2'b00, 2'b01: win_open = vblank;
            2'b10:        win_open = hblank | vblank;
            default:      win_open = 1'b1;
        endcase
    end

    assign pop = (state_q == S_IDLE) & (count_q != '0) & win_open;

    assign wr_ptr_d = wr_ptr_q + AW'(alloc);
    assign rd_ptr_d = rd_ptr_q + AW'(pop);
    assign count_d  = count_q + CW'(alloc) - CW'(pop);

    always_ff @(posedge clk) begin
        if (alloc) begin
            mem_q[wr_ptr_q] <= cmd_ent;
        end
`ifdef GFX_SCHED_COALESCE_EN
        else if (merge) begin
            mem_q[last_ptr].a   <= cmd_a;
            mem_q[last_ptr].b   <= cmd_b;
            mem_q[last_ptr].vis <= cmd_vis;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        pos_we_d  = 1'b0;
        attr_we_d = 1'b0;
        font_we_d = 1'b0;
        sel_d     = sel_q;
        x_d       = x_q;
        y_d       = y_q;
        vis_d     = vis_q;
        faddr_d   = faddr_q;
        fdata_d   = fdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    unique case (head.typ)
                        2'b00, 2'b01: begin
                            pos_we_d  = (head.typ == 2'b00);
                            attr_we_d = (head.typ == 2'b01);
                            sel_d     = head.sel;
                            x_d       = head.a[9:0];
                            y_d       = head.b;
                            vis_d     = head.vis;
                            state_d   = S_ISSUE;
                        end
                        2'b10: begin
                            font_we_d = 1'b1;
                            faddr_d   = head.a;
                            fdata_d   = head.b[3:0];
                            state_d   = S_ISSUE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_ISSUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pos_we_q  <= 1'b0;
            attr_we_q <= 1'b0;
            font_we_q <= 1'b0;
            sel_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            vis_q     <= 1'b0;
            faddr_q   <= '0;
            fdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pos_we_q  <= pos_we_d;
            attr_we_q <= attr_we_d;
            font_we_q <= font_we_d;
            sel_q     <= sel_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vis_q     <= vis_d;
            faddr_q   <= faddr_d;
            fdata_q   <= fdata_d;
        end
    end

    assign spr_pos_we  = pos_we_q;
    assign spr_attr_we = attr_we_q;
    assign font_we     = font_we_q;
    assign spr_sel     = sel_q;
    assign spr_x       = x_q;
    assign spr_y       = y_q;
    assign spr_vis     = vis_q;
    assign font_addr   = faddr_q;
    assign font_data   = fdata_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_gfx_cmd_sched.sv
// Bench for gfx_cmd_sched: per-cycle vector table plus fill/drain,
// coalescing and reset-during-issue sequences.
module tb_gfx_cmd_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_type;
    logic [4:0]  cmd_sel;
    logic [10:0] cmd_a;
    logic [8:0]  cmd_b;
    logic        cmd_vis;
    logic        vblank;
    logic        hblank;
    logic        stall;
    logic        spr_pos_we;
    logic        spr_attr_we;
    logic [4:0]  spr_sel;
    logic [9:0]  spr_x;
    logic [8:0]  spr_y;
    logic        spr_vis;
    logic        font_we;
    logic [10:0] font_addr;
    logic [3:0]  font_data;
    logic [3:0]  fifo_count;

    int n_chk = 0;
    int n_fail = 0;

    gfx_cmd_sched #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_vis(cmd_vis), .vblank(vblank), .hblank(hblank),
        .stall(stall), .spr_pos_we(spr_pos_we),
        .spr_attr_we(spr_attr_we), .spr_sel(spr_sel),
        .spr_x(spr_x), .spr_y(spr_y), .spr_vis(spr_vis),
        .font_we(font_we), .font_addr(font_addr),
        .font_data(font_data), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  t;
        logic [4:0]  sel;
        logic [10:0] a;
        logic [8:0]  b;
        logic        vis, vb, hb;
        logic        st, pw, aw, fw;
        logic [3:0]  cnt;
        logic [4:0]  ssel;
        logic [9:0]  sx;
        logic [8:0]  sy;
        logic        svis;
        logic [10:0] fa;
        logic [3:0]  fd;
    } vec_t;

    vec_t tv [18];

    task automatic chk(input string nm, input logic [47:0] got,
                       input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic v, input logic [1:0] t,
                       input logic [4:0] s, input logic [10:0] a,
                       input logic [8:0] b, input logic vis);
        cmd_valid = v;
        cmd_type  = t;
        cmd_sel   = s;
        cmd_a     = a;
        cmd_b     = b;
        cmd_vis   = vis;
    endtask

    function automatic logic [47:0] bundle();
        return {stall, spr_pos_we, spr_attr_we, font_we, fifo_count,
                spr_sel, spr_x, spr_y, spr_vis, font_addr, font_data};
    endfunction

    initial begin
        int n, last, nf, np, first_kind;
        logic [9:0] firstx, lastx;
        logic got_strobe;

        tv[0]  = '{1'b1,2'd0,5'd3,11'h12C,9'h0F0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,4'd1,5'd0,10'h000,9'h000,1'b0,11'h000,4'h0};
        tv[1]  = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,4'd0,5'd3,10'h12C,9'h0F0,1'b1,11'h000,4'h0};
        tv[2]  = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,4'd0,5'd3,10'h12C,9'h0F0,1'b1,11'h000,4'h0};
        tv[3]  = '{1'b1,2'd1,5'd7,11'h005,9'h011,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,4'd1,5'd3,10'h12C,9'h0F0,1'b1,11'h000,4'h0};
        tv[4]  = '{1'b1,2'd2,5'd0,11'h7FF,9'h00A,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,4'd2,5'd3,10'h12C,9'h0F0,1'b1,11'h000,4'h0};
        tv[5]  = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,4'd2,5'd3,10'h12C,9'h0F0,1'b1,11'h000,4'h0};
        tv[6]  = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,4'd1,5'd7,10'h005,9'h011,1'b0,11'h000,4'h0};
        tv[7]  = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,4'd1,5'd7,10'h005,9'h011,1'b0,11'h000,4'h0};
        tv[8]  = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,4'd0,5'd7,10'h005,9'h011,1'b0,11'h7FF,4'hA};
        tv[9]  = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,4'd0,5'd7,10'h005,9'h011,1'b0,11'h7FF,4'hA};
        tv[10] = '{1'b1,2'd2,5'd0,11'h001,9'h003,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,4'd1,5'd7,10'h005,9'h011,1'b0,11'h7FF,4'hA};
        tv[11] = '{1'b1,2'd3,5'd0,11'h000,9'h000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,4'd2,5'd7,10'h005,9'h011,1'b0,11'h7FF,4'hA};
        tv[12] = '{1'b1,2'd2,5'd0,11'h002,9'h005,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,4'd3,5'd7,10'h005,9'h011,1'b0,11'h7FF,4'hA};
        tv[13] = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,4'd2,5'd7,10'h005,9'h011,1'b0,11'h001,4'h3};
        tv[14] = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,4'd2,5'd7,10'h005,9'h011,1'b0,11'h001,4'h3};
        tv[15] = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,4'd1,5'd7,10'h005,9'h011,1'b0,11'h001,4'h3};
        tv[16] = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,4'd0,5'd7,10'h005,9'h011,1'b0,11'h002,4'h5};
        tv[17] = '{1'b0,2'd0,5'd0,11'h000,9'h000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,4'd0,5'd7,10'h005,9'h011,1'b0,11'h002,4'h5};

        reset = 1'b0;
        cmd(1'b0, 2'd0, 5'd0, 11'd0, 9'd0, 1'b0);
        vblank = 1'b0;
        hblank = 1'b0;
        #12;
        chk("reset_state", bundle(), 48'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;

        for (int i = 0; i < 18; i++) begin
            cmd(tv[i].v, tv[i].t, tv[i].sel, tv[i].a, tv[i].b, tv[i].vis);
            vblank = tv[i].vb;
            hblank = tv[i].hb;
            tick();
            chk($sformatf("vec%0d", i), bundle(),
                {tv[i].st, tv[i].pw, tv[i].aw, tv[i].fw, tv[i].cnt,
                 tv[i].ssel, tv[i].sx, tv[i].sy, tv[i].svis,
                 tv[i].fa, tv[i].fd});
        end

        // fill with windows closed; the ninth push must be held off
        vblank = 1'b0;
        hblank = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cmd(1'b1, 2'd2, 5'd0, 11'(i), 9'(i), 1'b0);
            tick();
            if (i == 6) chk("fill7_stall", 48'(stall), 48'd0);
        end
        chk("fill8_stall", 48'(stall), 48'd1);
        cmd(1'b1, 2'd2, 5'd0, 11'h55, 9'h5, 1'b0);
        tick();
        chk("fill9_count", 48'(fifo_count), 48'd8);
        cmd(1'b0, 2'd0, 5'd0, 11'd0, 9'd0, 1'b0);
        hblank = 1'b1;
        n = 0;
        last = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (font_we) begin
                chk($sformatf("drain%0d_addr", n),
                    48'({font_addr, font_data}),
                    48'({11'(n), 4'(n)}));
                if (n == 0)
                    chk("drain_stall_drop", 48'({stall, fifo_count}),
                        48'({1'b0, 4'd7}));
                else
                    chk($sformatf("drain%0d_gap", n), 48'(c - last), 48'd2);
                last = c;
                n++;
            end
        end
        chk("drain_count", 48'(n), 48'd8);
        hblank = 1'b0;

        // coalescing of repeated sprite-position pushes
        cmd(1'b1, 2'd2, 5'd0, 11'h100, 9'h001, 1'b0);
        tick();
        cmd(1'b1, 2'd0, 5'd5, 11'd10, 9'd0, 1'b1);
        tick();
        cmd(1'b1, 2'd0, 5'd5, 11'd20, 9'd0, 1'b1);
        tick();
        cmd(1'b0, 2'd0, 5'd0, 11'd0, 9'd0, 1'b0);
`ifdef GFX_SCHED_COALESCE_EN
        chk("coal_count", 48'(fifo_count), 48'd2);
`else
        chk("coal_count", 48'(fifo_count), 48'd3);
`endif
        vblank = 1'b1;
        nf = 0;
        np = 0;
        first_kind = 0;
        firstx = '0;
        lastx = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (font_we) begin
                if (nf + np == 0) first_kind = 1;
                nf++;
            end
            if (spr_pos_we) begin
                if (nf + np == 0) first_kind = 2;
                if (np == 0) firstx = spr_x;
                lastx = spr_x;
                np++;
            end
        end
        chk("coal_font_first", 48'(first_kind), 48'd1);
        chk("coal_font_n", 48'(nf), 48'd1);
        chk("coal_last_x", 48'(lastx), 48'd20);
`ifdef GFX_SCHED_COALESCE_EN
        chk("coal_spr_n", 48'(np), 48'd1);
`else
        chk("coal_spr_n", 48'(np), 48'd2);
        chk("coal_first_x", 48'(firstx), 48'd10);
`endif
        vblank = 1'b0;

        // reset asserted while a strobe is high
        cmd(1'b1, 2'd2, 5'd0, 11'h0AA, 9'h00C, 1'b0);
        tick();
        cmd(1'b1, 2'd2, 5'd0, 11'h0BB, 9'h00D, 1'b0);
        tick();
        cmd(1'b0, 2'd0, 5'd0, 11'd0, 9'd0, 1'b0);
        hblank = 1'b1;
        got_strobe = 1'b0;
        for (int c = 0; c < 10 && !got_strobe; c++) begin
            tick();
            if (font_we) got_strobe = 1'b1;
        end
        chk("rst_strobe_seen", 48'(got_strobe), 48'd1);
        chk("rst_pre_count", 48'(fifo_count), 48'd1);
        reset = 1'b0;
        #1;
        chk("rst_async", 48'({font_we, fifo_count, stall, font_addr}),
            48'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (font_we | spr_pos_we | spr_attr_we) n++;
        end
        chk("rst_no_stale", 48'({4'(n), fifo_count}), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gfx_cmd_sched.md
# gfx_cmd_sched

Graphics command scheduler between the execute stage and the video tables. It buffers sprite-position, sprite-attribute and font-write commands in an in-order FIFO. It releases each command to the sprite table or font RAM only while the scanout engine is not reading that table: sprite commands wait for vertical blank, font commands for horizontal or vertical blank. When the FIFO is full it raises a stall so no command is ever lost.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CW`, $clog2(DEPTH)+1: width of `fifo_count`.

- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present this cycle.
- `cmd_type` in 2: command type.
  - 00 sprite position
  - 01 sprite attribute
  - 10 font write
  - 11 reserved
- `cmd_sel` in 5: sprite index.
- `cmd_a` in 11: sprite X in [9:0], or font address.
- `cmd_b` in 9: sprite Y, or font data in [3:0].
- `cmd_vis` in 1: sprite visible bit.
- `vblank` in 1: scanout is in vertical blank.
- `hblank` in 1: scanout is in horizontal blank.
- `stall` out 1: FIFO full; the pipeline must hold its command.
- `spr_pos_we`, `spr_attr_we` out 1: sprite table write strobes.
- `spr_sel` out 5, `spr_x` out 10, `spr_y` out 9, `spr_vis` out 1: sprite write data.
- `font_we` out 1: font RAM write strobe.
- `font_addr` out 11, `font_data` out 4: font write data.
- `fifo_count` out CW: current occupancy.

## Operation
- **Push:** occurs on a rising edge when `cmd_valid & ~stall`. `stall = (fifo_count == DEPTH)`, combinational from the count. A push while full is ignored.
- **Entry format:** {type, sel, a, b, vis}, 28 bits. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- **Window per head type:**
  - sprite (00/01): `vblank`
  - font (10): `hblank | vblank`
  - reserved (11): always open
- **FSM, two states:**
  - IDLE: if the FIFO is non-empty and the head's window is open, pop the head. A type 00/01/10 head goes to ISSUE with its outputs registered. A type 11 head is dropped and the FSM stays in IDLE. If the window is closed, hold; the head blocks all later entries (strict order).
  - ISSUE: exactly one strobe is high for one cycle, then the FSM returns to IDLE unconditionally. This gives a mandatory gap cycle between writes.
- **Data outputs:** hold their last issued value between strobes. Only the strobe qualifies them.
- **Field mapping on issue:**
  - sprite: `spr_sel = sel`, `spr_x = a[9:0]`, `spr_y = b`, `spr_vis = vis`
  - font: `font_addr = a`, `font_data = b[3:0]`
- **Simultaneous push and pop:** both happen; `fifo_count` is unchanged.
- **Window closing during ISSUE:** the strobe still completes. The window is sampled only in IDLE.

## Timing
- **Reset (async, `reset` low):** all outputs and state clear immediately.
  - FSM IDLE, pointers 0, `fifo_count` 0, `stall` 0.
  - All strobes 0, all data outputs 0.
  - FIFO contents are discarded. A strobe in progress is cut off.
- **Latency:** a command accepted at edge E0 into an empty FIFO, with its window open at E1, drives its strobe high from E1 to E2.
- **Throughput:** at most one write per 2 cycles. A reserved drop takes 1 cycle.
- **Stall:** `stall` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the first pop.

## Configuration
- **Macro `GFX_SCHED_COALESCE_EN`, defined:** a sprite-position push merges into the newest entry instead of allocating a new one when all of the following hold:
  - `fifo_count >= 2`
  - the newest entry (`wr_ptr-1`) is type 00
  - its `sel` equals `cmd_sel`
  
  The merge overwrites that entry's a/b/vis fields. Pointers and count are unchanged. The head entry is never merged.
- **Coalescing when full:** with `stall` high, coalescing is still blocked. Stall has priority.
- **Macro undefined:** every accepted command allocates its own entry.

## Test plan
- **Basic sprite write:** push type 00, sel 3, a 0x12C, b 0x0F0, vis 1, with `vblank` 1 → `spr_pos_we` high exactly one cycle, 1 cycle after accept, with `spr_x` 300, `spr_y` 240, `spr_sel` 3.
- **Head-of-line blocking:** `vblank` 0, `hblank` 1; push sprite then font → no strobe. Raise `vblank` → sprite strobe, gap cycle, then `font_we` with addr/data intact.
- **Fill and drain:** with `DEPTH` 8 and windows closed, push 9 commands → `stall` high after the 8th, 9th held, `fifo_count` 8. Open the windows → 8 strobes 2 cycles apart in order, `stall` drops after the first pop.
- **Reset mid-run:** pull `reset` low during an ISSUE cycle → strobe and `fifo_count` go to 0 immediately. After release, no stale write appears.
- **Coalescing, macro defined:** windows closed; push font, then sprite sel 5 x=10, then sprite sel 5 x=20 → `fifo_count` 2; drains to one `font_we` then one `spr_pos_we` with x=20. With the macro undefined → count 3 and two sprite writes.
- **Reserved drop:** push type 11 between two font writes, all windows open → only 2 `font_we` strobes; the reserved entry is consumed in 1 cycle.
